// File: rtl/spi_master_pkg.sv
// Shared types for the SPI master transfer sequencer: phase states, op types
// and the phase-skipping rule.
package spi_master_pkg;

    localparam int unsigned CS_NUM_DEF = 4;
    localparam int unsigned LEN_W_DEF  = 16;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BLEN_W     = 6;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned NUM_STATES = 7;

    localparam int unsigned ST_IDLE_BIT    = 0;
    localparam int unsigned ST_CMD_BIT     = 1;
    localparam int unsigned ST_ADDR_BIT    = 2;
    localparam int unsigned ST_DUMMY_BIT   = 3;
    localparam int unsigned ST_DATA_TX_BIT = 4;
    localparam int unsigned ST_DATA_RX_BIT = 5;
    localparam int unsigned ST_EOT_BIT     = 6;

    // One-hot so the state register doubles as the status word.
    typedef enum logic [NUM_STATES-1:0] {
        ST_IDLE    = 7'b000_0001,
        ST_CMD     = 7'b000_0010,
        ST_ADDR    = 7'b000_0100,
        ST_DUMMY   = 7'b000_1000,
        ST_DATA_TX = 7'b001_0000,
        ST_DATA_RX = 7'b010_0000,
        ST_EOT     = 7'b100_0000
    } state_e;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_QRD = 2'd2,
        OP_QWR = 2'd3
    } op_e;

    function automatic logic op_is_write(op_e op);
        return (op == OP_WR) || (op == OP_QWR);
    endfunction

    function automatic logic op_is_quad(op_e op);
        return (op == OP_QRD) || (op == OP_QWR);
    endfunction

    // First phase after cur whose latched length is nonzero, else EOT.
    function automatic state_e next_phase(
        state_e              cur,
        op_e                 op,
        logic [BLEN_W-1:0]   cmd_len,
        logic [BLEN_W-1:0]   addr_len,
        logic [CNT_W-1:0]    dummy,
        logic [CNT_W-1:0]    data_len
    );
        state_e nxt;
        nxt = ST_EOT;
        if ((cur == ST_IDLE) && (cmd_len != '0)) begin
            nxt = ST_CMD;
        end else if ((cur inside {ST_IDLE, ST_CMD}) && (addr_len != '0)) begin
            nxt = ST_ADDR;
        end else if ((cur inside {ST_IDLE, ST_CMD, ST_ADDR}) && (dummy != '0)) begin
            nxt = ST_DUMMY;
        end else if ((cur inside {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY}) && (data_len != '0)) begin
            nxt = op_is_write(op) ? ST_DATA_TX : ST_DATA_RX;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/spi_master_seq_if.sv
// Sequencer-facing bundle: register-block op strobes and lengths in,
// shifter handshakes, chip selects and status out.
interface spi_master_seq_if
    import spi_master_pkg::*;
#(
    parameter int unsigned CS_NUM = CS_NUM_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
);
    logic                spi_rd;
    logic                spi_wr;
    logic                spi_qrd;
    logic                spi_qwr;
    logic                spi_swrst;
    logic [CS_NUM-1:0]   spi_csreg;
    logic [WORD_W-1:0]   spi_cmd;
    logic [BLEN_W-1:0]   spi_cmd_len;
    logic [WORD_W-1:0]   spi_addr;
    logic [BLEN_W-1:0]   spi_addr_len;
    logic [CNT_W-1:0]    spi_data_len;
    logic [CNT_W-1:0]    spi_dummy_rd;
    logic [CNT_W-1:0]    spi_dummy_wr;
    logic                spi_edge;

    logic                tx_start;
    logic [WORD_W-1:0]   tx_data;
    logic [LEN_W-1:0]    tx_len;
    logic                tx_quad;
    logic                tx_is_data;
    logic                tx_done;
    logic                rx_start;
    logic [LEN_W-1:0]    rx_len;
    logic                rx_quad;
    logic                rx_done;
    logic                spi_clk_en;
    logic [CS_NUM-1:0]   spi_csn;
    logic                shifter_clr;
    logic [WORD_W-1:0]   spi_status;
    logic                eot;

    modport master (
        input  spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst, spi_csreg,
               spi_cmd, spi_cmd_len, spi_addr, spi_addr_len, spi_data_len,
               spi_dummy_rd, spi_dummy_wr, spi_edge, tx_done, rx_done,
        output tx_start, tx_data, tx_len, tx_quad, tx_is_data,
               rx_start, rx_len, rx_quad, spi_clk_en, spi_csn,
               shifter_clr, spi_status, eot
    );

    modport slave (
        output spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst, spi_csreg,
               spi_cmd, spi_cmd_len, spi_addr, spi_addr_len, spi_data_len,
               spi_dummy_rd, spi_dummy_wr, spi_edge, tx_done, rx_done,
        input  tx_start, tx_data, tx_len, tx_quad, tx_is_data,
               rx_start, rx_len, rx_quad, spi_clk_en, spi_csn,
               shifter_clr, spi_status, eot
    );

endinterface

// File: rtl/spi_master_seq.sv
// Transfer sequencer for the APB SPI master: walks CMD/ADDR/DUMMY/DATA phases,
// issues shifter start pulses, drives chip selects and flags end of transfer.
module spi_master_seq
    import spi_master_pkg::*;
#(
    parameter int unsigned CS_NUM = CS_NUM_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    spi_master_seq_if.master bus
);

    state_e              r_state,      w_state_nxt;
    op_e                 r_op,         w_op_nxt;
    logic [CS_NUM-1:0]   r_cs,         w_cs_nxt;
    logic [WORD_W-1:0]   r_cmd,        w_cmd_nxt;
    logic [WORD_W-1:0]   r_addr,       w_addr_nxt;
    logic [BLEN_W-1:0]   r_cmd_len,    w_cmd_len_nxt;
    logic [BLEN_W-1:0]   r_addr_len,   w_addr_len_nxt;
    logic [CNT_W-1:0]    r_data_len,   w_data_len_nxt;
    logic [CNT_W-1:0]    r_dummy,      w_dummy_nxt;
    logic [CNT_W-1:0]    r_dcnt,       w_dcnt_nxt;

    logic                r_tx_start,   w_tx_start_nxt;
    logic [WORD_W-1:0]   r_tx_data,    w_tx_data_nxt;
    logic [LEN_W-1:0]    r_tx_len,     w_tx_len_nxt;
    logic                r_tx_quad,    w_tx_quad_nxt;
    logic                r_tx_is_data, w_tx_is_data_nxt;
    logic                r_rx_start,   w_rx_start_nxt;
    logic [LEN_W-1:0]    r_rx_len,     w_rx_len_nxt;
    logic                r_rx_quad,    w_rx_quad_nxt;
    logic                r_clk_en,     w_clk_en_nxt;
    logic [CS_NUM-1:0]   r_csn,        w_csn_nxt;
    logic                r_clr,        w_clr_nxt;
    logic                r_eot,        w_eot_nxt;

    logic                w_accept;
    logic                w_enter;

    // Next-state, latch and phase-entry output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_op_nxt         = r_op;
        w_cs_nxt         = r_cs;
        w_cmd_nxt        = r_cmd;
        w_addr_nxt       = r_addr;
        w_cmd_len_nxt    = r_cmd_len;
        w_addr_len_nxt   = r_addr_len;
        w_data_len_nxt   = r_data_len;
        w_dummy_nxt      = r_dummy;
        w_dcnt_nxt       = r_dcnt;
        w_tx_start_nxt   = 1'b0;
        w_tx_data_nxt    = r_tx_data;
        w_tx_len_nxt     = r_tx_len;
        w_tx_quad_nxt    = r_tx_quad;
        w_tx_is_data_nxt = r_tx_is_data;
        w_rx_start_nxt   = 1'b0;
        w_rx_len_nxt     = r_rx_len;
        w_rx_quad_nxt    = r_rx_quad;
        w_clk_en_nxt     = r_clk_en;
        w_csn_nxt        = r_csn;
        w_clr_nxt        = 1'b0;
        w_eot_nxt        = 1'b0;
        w_accept         = 1'b0;
        w_enter          = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.spi_rd) begin
                    w_accept = 1'b1;
                    w_op_nxt = OP_RD;
                end else if (bus.spi_wr) begin
                    w_accept = 1'b1;
                    w_op_nxt = OP_WR;
                end else if (bus.spi_qrd) begin
                    w_accept = 1'b1;
                    w_op_nxt = OP_QRD;
                end else if (bus.spi_qwr) begin
                    w_accept = 1'b1;
                    w_op_nxt = OP_QWR;
                end
                if (w_accept) begin
                    w_cs_nxt       = bus.spi_csreg;
                    w_cmd_nxt      = bus.spi_cmd;
                    w_addr_nxt     = bus.spi_addr;
                    w_cmd_len_nxt  = bus.spi_cmd_len;
                    w_addr_len_nxt = bus.spi_addr_len;
                    w_data_len_nxt = bus.spi_data_len;
                    w_dummy_nxt    = op_is_write(w_op_nxt) ? bus.spi_dummy_wr
                                                           : bus.spi_dummy_rd;
                    w_state_nxt    = next_phase(ST_IDLE, w_op_nxt, w_cmd_len_nxt,
                                                w_addr_len_nxt, w_dummy_nxt,
                                                w_data_len_nxt);
                    w_enter        = 1'b1;
                end
            end
            ST_CMD, ST_ADDR: begin
                // done coinciding with the start pulse belongs to no transfer yet
                if (bus.tx_done && !r_tx_start) begin
                    w_state_nxt = next_phase(r_state, r_op, r_cmd_len, r_addr_len,
                                             r_dummy, r_data_len);
                    w_enter     = 1'b1;
                end
            end
            ST_DUMMY: begin
                if (bus.spi_edge) begin
                    if (r_dcnt == CNT_W'(1)) begin
                        w_state_nxt = next_phase(ST_DUMMY, r_op, r_cmd_len, r_addr_len,
                                                 r_dummy, r_data_len);
                        w_enter     = 1'b1;
                    end else begin
                        w_dcnt_nxt = r_dcnt - CNT_W'(1);
                    end
                end
            end
            ST_DATA_TX: begin
                if (bus.tx_done && !r_tx_start) begin
                    w_state_nxt = ST_EOT;
                    w_enter     = 1'b1;
                end
            end
            ST_DATA_RX: begin
                if (bus.rx_done && !r_rx_start) begin
                    w_state_nxt = ST_EOT;
                    w_enter     = 1'b1;
                end
            end
            ST_EOT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_csn_nxt    = {CS_NUM{1'b1}};
                w_clk_en_nxt = 1'b0;
            end
        endcase

        // Load the shifter view of the phase being entered.
        if (w_enter) begin
            w_csn_nxt    = ~w_cs_nxt;
            w_clk_en_nxt = 1'b1;
            unique case (w_state_nxt)
                ST_CMD: begin
                    w_tx_start_nxt   = 1'b1;
                    w_tx_data_nxt    = w_cmd_nxt;
                    w_tx_len_nxt     = LEN_W'(w_cmd_len_nxt);
                    w_tx_quad_nxt    = op_is_quad(w_op_nxt);
                    w_tx_is_data_nxt = 1'b0;
                end
                ST_ADDR: begin
                    w_tx_start_nxt   = 1'b1;
                    w_tx_data_nxt    = w_addr_nxt;
                    w_tx_len_nxt     = LEN_W'(w_addr_len_nxt);
                    w_tx_quad_nxt    = op_is_quad(w_op_nxt);
                    w_tx_is_data_nxt = 1'b0;
                end
                ST_DUMMY: begin
                    w_dcnt_nxt = w_dummy_nxt;
                end
                ST_DATA_TX: begin
                    w_tx_start_nxt   = 1'b1;
                    w_tx_data_nxt    = '0;
                    w_tx_len_nxt     = LEN_W'(w_data_len_nxt);
                    w_tx_quad_nxt    = (w_op_nxt == OP_QWR);
                    w_tx_is_data_nxt = 1'b1;
                end
                ST_DATA_RX: begin
                    w_rx_start_nxt = 1'b1;
                    w_rx_len_nxt   = LEN_W'(w_data_len_nxt);
                    w_rx_quad_nxt  = (w_op_nxt == OP_QRD);
                end
                default: begin
                    w_eot_nxt    = 1'b1;
                    w_csn_nxt    = {CS_NUM{1'b1}};
                    w_clk_en_nxt = 1'b0;
                end
            endcase
        end

        // Soft reset overrides any strobe or done seen in the same cycle.
        if (bus.spi_swrst) begin
            w_state_nxt    = ST_IDLE;
            w_tx_start_nxt = 1'b0;
            w_rx_start_nxt = 1'b0;
            w_eot_nxt      = 1'b0;
            w_csn_nxt      = {CS_NUM{1'b1}};
            w_clk_en_nxt   = 1'b0;
            w_clr_nxt      = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_RD;
            r_cs         <= '0;
            r_cmd        <= '0;
            r_addr       <= '0;
            r_cmd_len    <= '0;
            r_addr_len   <= '0;
            r_data_len   <= '0;
            r_dummy      <= '0;
            r_dcnt       <= '0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_tx_len     <= '0;
            r_tx_quad    <= 1'b0;
            r_tx_is_data <= 1'b0;
            r_rx_start   <= 1'b0;
            r_rx_len     <= '0;
            r_rx_quad    <= 1'b0;
            r_clk_en     <= 1'b0;
            r_csn        <= {CS_NUM{1'b1}};
            r_clr        <= 1'b0;
            r_eot        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_cs         <= w_cs_nxt;
            r_cmd        <= w_cmd_nxt;
            r_addr       <= w_addr_nxt;
            r_cmd_len    <= w_cmd_len_nxt;
            r_addr_len   <= w_addr_len_nxt;
            r_data_len   <= w_data_len_nxt;
            r_dummy      <= w_dummy_nxt;
            r_dcnt       <= w_dcnt_nxt;
            r_tx_start   <= w_tx_start_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_len     <= w_tx_len_nxt;
            r_tx_quad    <= w_tx_quad_nxt;
            r_tx_is_data <= w_tx_is_data_nxt;
            r_rx_start   <= w_rx_start_nxt;
            r_rx_len     <= w_rx_len_nxt;
            r_rx_quad    <= w_rx_quad_nxt;
            r_clk_en     <= w_clk_en_nxt;
            r_csn        <= w_csn_nxt;
            r_clr        <= w_clr_nxt;
            r_eot        <= w_eot_nxt;
        end
    end

    assign bus.tx_start    = r_tx_start;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_len      = r_tx_len;
    assign bus.tx_quad     = r_tx_quad;
    assign bus.tx_is_data  = r_tx_is_data;
    assign bus.rx_start    = r_rx_start;
    assign bus.rx_len      = r_rx_len;
    assign bus.rx_quad     = r_rx_quad;
    assign bus.spi_clk_en  = r_clk_en;
    assign bus.spi_csn     = r_csn;
    assign bus.shifter_clr = r_clr;
    assign bus.eot         = r_eot;
    assign bus.spi_status  = {(WORD_W - NUM_STATES)'(0), r_state};

endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
- Transfer sequencer for the APB SPI master.
- Consumes the one-cycle op strobes and the length/command/address/dummy registers produced by the APB register interface.
- Steps through the CMD, ADDR, DUMMY and DATA phases, driving start/length handshakes to the TX and RX shift engines and the chip selects.
- Reports its phase on spi_status and pulses eot at the end of each transfer.

Parameters:
- CS_NUM, 4, number of chip-select lines; width of spi_csreg and spi_csn.
- LEN_W, 16, width of bit/cycle counts handed to the shifters.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- spi_rd / spi_wr / spi_qrd / spi_qwr  in  1 each  one-cycle op strobes
- spi_swrst  in  1  one-cycle soft-reset strobe
- spi_csreg  in  CS_NUM  chip-select selection; bit i=1 selects device i
- spi_cmd  in  32  command word
- spi_cmd_len  in  6  command bits
- spi_addr  in  32  address word
- spi_addr_len  in  6  address bits
- spi_data_len  in  16  data bits
- spi_dummy_rd / spi_dummy_wr  in  16 each  dummy SCLK cycles for reads / writes
- spi_edge  in  1  one pulse per SCLK period from the clock generator
- tx_start  out  1  TX shifter start pulse
- tx_data  out  32  word to shift, MSB of the low tx_len bits first
- tx_len  out  LEN_W  bits to send
- tx_quad  out  1  quad mode
- tx_is_data  out  1  TX shifter sources data from the TX FIFO (DATA phase)
- tx_done  in  1  TX phase complete
- rx_start  out  1  RX shifter start pulse
- rx_len  out  LEN_W  bits to receive
- rx_quad  out  1  quad mode
- rx_done  in  1  RX phase complete
- spi_clk_en  out  1  enables SCLK generation
- spi_csn  out  CS_NUM  chip selects, active low
- shifter_clr  out  1  soft-reset pulse to the shifters and FIFOs
- spi_status  out  32  {25'b0, state one-hot[6:0]}
- eot  out  1  end-of-transfer pulse

Behaviour:
- Reset values: state IDLE; tx_start, rx_start, spi_clk_en, shifter_clr and eot = 0; spi_csn all 1s; all length and data outputs 0; spi_status = 32'h1.
- States and status bits:
  - IDLE = bit 0
  - CMD = bit 1
  - ADDR = bit 2
  - DUMMY = bit 3
  - DATA_TX = bit 4
  - DATA_RX = bit 5
  - EOT = bit 6
- Accept (IDLE only):
  - Strobe priority is rd > wr > qrd > qwr; lower-priority strobes in the same cycle are dropped.
  - On accept, latch op type, csreg, cmd, addr, all lengths and the dummy count (dummy_rd for rd/qrd, dummy_wr for wr/qwr).
  - Strobes outside IDLE are ignored, with no queuing.
- Phase order: CMD → ADDR → DUMMY → DATA → EOT.
  - The next state is the first later phase with a nonzero latched length; otherwise EOT.
  - All zero lengths go IDLE → EOT → IDLE.
- Latency:
  - A strobe sampled in cycle T gives the first phase state in T+1.
  - The matching tx_start or rx_start pulse is registered and also visible in T+1.
  - spi_csn = ~latched csreg and spi_clk_en = 1 from T+1.
- CMD phase: tx_data = cmd, tx_len = cmd_len (zero-extended), tx_quad = qrd|qwr. Leave on tx_done.
- ADDR phase: tx_data = addr, tx_len = addr_len, tx_quad = qrd|qwr. Leave on tx_done.
- DUMMY phase:
  - A 16-bit counter is loaded with the dummy count and decremented on each spi_edge.
  - Leave in the cycle the counter reads 1 and spi_edge = 1, so exactly N edges are consumed.
- DATA_TX phase (wr/qwr): tx_len = data_len, tx_is_data = 1, tx_quad = qwr. Leave on tx_done.
- DATA_RX phase (rd/qrd): rx_len = data_len, rx_quad = qrd. Leave on rx_done.
- Handshake rules:
  - Start pulses are exactly 1 cycle.
  - len, data and quad outputs are held stable from start until done.
  - done is accepted no earlier than the cycle after start.
  - done arriving in any other state is ignored.
  - The next phase's start is issued in the cycle after done, together with the state change.
- EOT:
  - Lasts 1 cycle with eot = 1; spi_csn all 1s and spi_clk_en = 0 from EOT entry.
  - Then IDLE. A strobe present during EOT is ignored.
- Soft reset:
  - spi_swrst in any state forces IDLE at the next edge, with csn all 1s, clk_en = 0 and starts = 0.
  - shifter_clr = 1 for that one cycle; no eot is produced.
  - spi_swrst wins over a simultaneous op strobe or done.
- HRESETn mid-transfer: immediate return to the reset values.

Decomposition:
- spi_master_pkg holds:
  - the state enum and status bit positions;
  - the op type enum (RD, WR, QRD, QWR);
  - a next_phase function taking the current state, op and latched lengths.
- The FSM and counters are kept in a single module; no sub-module.

Test Plan:
- cmd_len=8, cmd=0x9F, addr_len=0, dummy_rd=0, data_len=24, rd strobe, csreg=4'b0001:
  - tx_start with tx_len=8 one cycle after the strobe;
  - rx_start with rx_len=24 one cycle after tx_done;
  - eot one cycle after rx_done;
  - spi_csn=4'b1110 throughout, 4'b1111 after.
- qwr with cmd_len=8, addr_len=24, addr=0x123456, dummy_wr=0, data_len=32:
  - spi_status sequence 0x2 → 0x4 → 0x10 → 0x40 → 0x1;
  - tx_quad=1 in every phase.
- qrd with dummy_rd=6:
  - DUMMY lasts exactly 6 spi_edge pulses, even when spi_edge is issued every 3 cycles;
  - then rx_start fires.
- rd and wr strobed in the same cycle → read sequence only. wr strobe during CMD → ignored, and eot count stays 1.
- spi_swrst during DATA_RX:
  - IDLE next cycle, shifter_clr pulse, csn=4'b1111, no eot;
  - a later rx_done is ignored.
- All lengths 0, wr strobe → EOT the next cycle, eot pulse, no tx_start or rx_start.
